// File: rtl/tybec_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tybec_axi_mem_responder
//  Purpose  : AXI4 memory-mapped responder standing in for device DDR in local
//             simulation / loopback builds. One word-addressed memory array,
//             byte-strobed writes, INCR bursts only, OKAY responses only.
//             Independent read and write FSMs, so kernel read and write
//             masters can run concurrently.
//  Ports    : aclk / aresetn (async, active-low)
//             AW: s_axi_awvalid/awready/awaddr/awlen
//             W : s_axi_wvalid/wready/wdata/wstrb/wlast
//             B : s_axi_bvalid/bready
//             AR: s_axi_arvalid/arready/araddr/arlen
//             R : s_axi_rvalid/rready/rdata/rlast
//             err_wlast : sticky wlast/beat-count mismatch flag
//  Options  : TYBEC_AXI_RESP_STALL_EN - LFSR-driven pseudo-random backpressure
//  Revision : 1.0 - initial release
// ============================================================================
module tybec_axi_mem_responder #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast
);

  localparam int LP_DW_BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int LP_OFF_W    = $clog2(LP_DW_BYTES);
  localparam int LP_IDX_W    = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  logic [C_M_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;
  logic [LP_IDX_W-1:0] wptr, rptr, aw_idx, ar_idx;
  logic [7:0]          wcnt, rcnt;
  logic                active;   // keeps all readies low until the first edge after reset
  logic                b_shown;  // bvalid already presented, must hold until accepted
  logic                r_shown;  // rvalid already presented, must hold until accepted
  logic                stall;
  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                unused_addr_bits;

  // Offset bits and bits above the index are deliberately ignored (aliasing).
  assign aw_idx = s_axi_awaddr[LP_IDX_W+LP_OFF_W-1:LP_OFF_W];
  assign ar_idx = s_axi_araddr[LP_IDX_W+LP_OFF_W-1:LP_OFF_W];
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

`ifdef TYBEC_AXI_RESP_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) active <= 1'b0;
    else          active <= 1'b1;
  end

  // ---------------- write channel ----------------
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: s_axi_awready = active & ~stall;
      W_DATA: s_axi_wready  = ~stall;
      W_RESP: s_axi_bvalid  = b_shown | ~stall;
      default: ;
    endcase
    aw_hs = s_axi_awvalid & s_axi_awready;
    w_hs  = s_axi_wvalid  & s_axi_wready;
    b_hs  = s_axi_bvalid  & s_axi_bready;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && wcnt == 8'd0) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr      <= '0;
      wcnt      <= 8'd0;
      err_wlast <= 1'b0;
      b_shown   <= 1'b0;
    end else begin
      b_shown <= s_axi_bvalid & ~s_axi_bready;
      if (aw_hs) begin
        wptr <= aw_idx;
        wcnt <= s_axi_awlen;
      end
      if (w_hs) begin
        wptr <= wptr + LP_IDX_W'(1);
        if (wcnt != 8'd0) wcnt <= wcnt - 8'd1;
        // Burst length is governed by awlen; wlast is only audited.
        if (s_axi_wlast != (wcnt == 8'd0)) err_wlast <= 1'b1;
      end
    end
  end

  // Memory has no reset so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int b = 0; b < LP_DW_BYTES; b++) begin
        if (s_axi_wstrb[b]) mem[wptr][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE:  s_axi_arready = active & ~stall;
      R_DATA:  s_axi_rvalid  = r_shown | ~stall;
      default: ;
    endcase
    s_axi_rlast = s_axi_rvalid & (rcnt == 8'd0);
    ar_hs = s_axi_arvalid & s_axi_arready;
    r_hs  = s_axi_rvalid  & s_axi_rready;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rcnt == 8'd0) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // rdata is a registered read, so a same-cycle write to the same word
  // is seen only on the following access (old data returned).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rptr        <= '0;
      rcnt        <= 8'd0;
      s_axi_rdata <= '0;
      r_shown     <= 1'b0;
    end else begin
      // Once shown, rvalid stays up through back-to-back beats until the last.
      r_shown <= s_axi_rvalid & ~(s_axi_rready & (rcnt == 8'd0));
      if (ar_hs) begin
        s_axi_rdata <= mem[ar_idx];
        rptr        <= ar_idx + LP_IDX_W'(1);
        rcnt        <= s_axi_arlen;
      end else if (r_hs && rcnt != 8'd0) begin
        s_axi_rdata <= mem[rptr];
        rptr        <= rptr + LP_IDX_W'(1);
        rcnt        <= rcnt - 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tybec_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tybec_axi_mem_responder
//  Purpose  : Self-checking bench for tybec_axi_mem_responder (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tybec_axi_mem_responder;
  localparam int AW = 64, DW = 512, DEPTH = 1024, NB = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [7:0]    s_axi_awlen;
  logic          s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata;
  logic [NB-1:0] s_axi_wstrb;
  logic          s_axi_wlast;
  logic          s_axi_bvalid, s_axi_bready;
  logic          s_axi_arvalid, s_axi_arready;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic          s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_rdata;
  logic          s_axi_rlast;
  logic          err_wlast;

  always #5 aclk = ~aclk;

  tybec_axi_mem_responder #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_MEM_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
    .err_wlast(err_wlast)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] beat_data [256];

  typedef struct {
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [NB-1:0] strb;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs [6];

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for handshake", nm);
  endtask

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[15:6]);
  endfunction

  task automatic wr_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [NB-1:0] strb, input int wl_beat);
    int n;
    int w;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin step; n++; end
    if (!s_axi_awready) expire("aw");
    step;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = beat_data[i];
      s_axi_wstrb = strb;  s_axi_wlast = (i == wl_beat);
      n = 0;
      while (!s_axi_wready && n < 50) begin step; n++; end
      if (!s_axi_wready) expire("w");
      w = (idx(addr) + i) % DEPTH;
      for (int b = 0; b < NB; b++)
        if (strb[b]) model[w][b*8 +: 8] = beat_data[i][b*8 +: 8];
      step;
      if (wl_beat != int'(len)) chk($sformatf("err_wlast_beat%0d", i), err_wlast, (i >= wl_beat) ? 1 : 0);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("bvalid_after_last", s_axi_bvalid, 1);
    step;
    chk("bvalid_cleared", s_axi_bvalid, 0);
    chk("awready_after_b", s_axi_awready, 1);
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                          output logic [DW-1:0] last_data);
    int n;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin step; n++; end
    if (!s_axi_arready) expire("ar");
    step;
    s_axi_arvalid = 1'b0;
    chk("rvalid_latency", s_axi_rvalid, 1);
    last_data = '0;
    for (int i = 0; i <= int'(len); i++) begin
      chk($sformatf("rdata_beat%0d", i), s_axi_rdata, model[(idx(addr) + i) % DEPTH]);
      chk($sformatf("rlast_beat%0d", i), s_axi_rlast, (i == int'(len)) ? 1 : 0);
      last_data = s_axi_rdata;
      step;
    end
    chk("rvalid_end", s_axi_rvalid, 0);
  endtask

  initial begin
    logic [DW-1:0] ld;
    int k;
    int cyc;

    vecs[0] = '{64'(3*64), 64'(3*64), '1, '1, '1};
    vecs[1] = '{64'(3*64), 64'(3*64), 64'h1, '0, {{504{1'b1}}, 8'h00}};
    vecs[2] = '{64'(7*64), 64'(7*64), '1, {8{64'h0123456789ABCDEF}}, {8{64'h0123456789ABCDEF}}};
    vecs[3] = '{64'(7*64), 64'(7*64), 64'hF0, '0,
                {{7{64'h0123456789ABCDEF}}, 64'h0000000089ABCDEF}};
    vecs[4] = '{64'hF000_0000_0000_0000 + 64'(9*64) + 64'd5, 64'(9*64), '1,
                {16{32'hDEADBEEF}}, {16{32'hDEADBEEF}}};
    vecs[5] = '{64'(11*64), 64'h0000_0001_0000_0000 + 64'(11*64) + 64'd63, '1,
                {16{32'h5A5A0011}}, {16{32'h5A5A0011}}};

    // ---- reset ----
    aresetn = 1'b0;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
    s_axi_bready = 1; s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_rready = 1;
    step; step; step;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_err_wlast", err_wlast, 0);
    aresetn = 1'b1;
    chk("arready_before_edge", s_axi_arready, 0);
    step;
    chk("awready_after_release", s_axi_awready, 1);
    chk("arready_after_release", s_axi_arready, 1);

    // ---- 16-beat write then read-back ----
    for (int i = 0; i < 16; i++) beat_data[i] = DW'(i);
    wr_burst(64'h0, 8'd15, '1, 15);
    rd_burst(64'h0, 8'd15, ld);
    chk("burst16_last", ld, DW'(15));

    // ---- table-driven single-beat vectors (strobes, aliasing) ----
    for (int v = 0; v < 6; v++) begin
      beat_data[0] = vecs[v].data;
      wr_burst(vecs[v].waddr, 8'd0, vecs[v].strb, 0);
      rd_burst(vecs[v].raddr, 8'd0, ld);
      chk($sformatf("vec%0d", v), ld, vecs[v].exp);
    end

    // ---- wrap from last word to word 0 ----
    for (int i = 0; i < 4; i++) beat_data[i] = DW'(100 + i);
    wr_burst(64'((DEPTH-2)*64), 8'd3, '1, 3);
    rd_burst(64'((DEPTH-2)*64), 8'd3, ld);
    chk("wrap_last_word1", ld, DW'(103));
    rd_burst(64'h0, 8'd0, ld);
    chk("wrap_word0", ld, DW'(102));
    chk("wrap_err_wlast", err_wlast, 0);

    // ---- rready toggling on 8-beat read ----
    s_axi_araddr = 64'h0; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
    chk("tog_arready", s_axi_arready, 1);
    step;
    s_axi_arvalid = 1'b0;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 40) begin
      s_axi_rready = ((cyc % 2) == 0);
      chk($sformatf("tog_rvalid_c%0d", cyc), s_axi_rvalid, 1);
      chk($sformatf("tog_rdata_c%0d", cyc), s_axi_rdata, model[k]);
      chk($sformatf("tog_rlast_c%0d", cyc), s_axi_rlast, (k == 7) ? 1 : 0);
      if (s_axi_rvalid && s_axi_rready) k++;
      step;
      cyc++;
    end
    s_axi_rready = 1'b1;
    chk("tog_handshakes", DW'(k), DW'(8));
    chk("tog_rvalid_end", s_axi_rvalid, 0);

    // ---- simultaneous AW + AR ----
    s_axi_awaddr = 64'(50*64); s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
    s_axi_araddr = 64'(3*64);  s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    chk("sim_awready", s_axi_awready, 1);
    chk("sim_arready", s_axi_arready, 1);
    step;
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    chk("sim_wready", s_axi_wready, 1);
    chk("sim_rvalid", s_axi_rvalid, 1);
    chk("sim_rdata", s_axi_rdata, {{504{1'b1}}, 8'h00});
    s_axi_wvalid = 1'b1; s_axi_wdata = {16{32'hC0FFEE00}}; s_axi_wstrb = '1; s_axi_wlast = 1'b1;
    model[50] = {16{32'hC0FFEE00}};
    step;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("sim_bvalid", s_axi_bvalid, 1);
    chk("sim_rvalid_done", s_axi_rvalid, 0);
    step;
    rd_burst(64'(50*64), 8'd0, ld);
    chk("sim_readback", ld, {16{32'hC0FFEE00}});

    // ---- wlast mismatch: wlast on beat 1 of 4 ----
    for (int i = 0; i < 4; i++) beat_data[i] = DW'(200 + i);
    wr_burst(64'(20*64), 8'd3, '1, 1);
    chk("err_wlast_sticky", err_wlast, 1);
    beat_data[0] = DW'(77);
    wr_burst(64'(30*64), 8'd0, '1, 0);
    chk("err_wlast_still", err_wlast, 1);
    rd_burst(64'(20*64), 8'd3, ld);
    chk("err_burst_data", ld, DW'(203));

    // ---- reset in the middle of an 8-beat read ----
    s_axi_araddr = 64'h0; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
    step;
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) step;
    chk("mid_rdata_beat4", s_axi_rdata, model[4]);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_rvalid", s_axi_rvalid, 0);
    chk("mid_rst_rdata", s_axi_rdata, 0);
    chk("mid_rst_arready", s_axi_arready, 0);
    chk("mid_rst_err_wlast", err_wlast, 0);
    step;
    aresetn = 1'b1;
    chk("mid_arready_pre", s_axi_arready, 0);
    step;
    chk("mid_arready_post", s_axi_arready, 1);
    rd_burst(64'(7*64), 8'd0, ld);
    chk("mid_readback", ld, {{7{64'h0123456789ABCDEF}}, 64'h0000000089ABCDEF});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
